// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the loader top level and its word assembler.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      WRITE,
      FINISH,
      ERR
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_STRIDE    = 4;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Byte-lane shift register that packs four stream bytes into one word.
// The first byte accepted ends up in bits [7:0].
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   input  logic        byte_en,
   output logic [31:0] word_out,
   output logic        word_full
);

   logic [1:0] byte_idx;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         byte_idx <= '0;
         word_out <= '0;
      end else if (byte_en) begin
         word_out <= {byte_in, word_out[31:8]};
         byte_idx <= byte_idx + 2'd1;
      end
   end

   assign word_full = byte_en
                   && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program into instruction memory,
// stalling the core while loading and restarting its PC afterwards.
module imem_boot_loader
   import imem_loader_pkg::*;
#(
   parameter int                     INS_ADDRESS = 32,
   parameter int                     INS_W       = 32,
   parameter logic [INS_ADDRESS-1:0] BASE_ADDR   = '0,
   parameter int                     MAX_WORDS   = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic                   rx_ready,
   output logic                   imem_we,
   output logic [INS_ADDRESS-1:0] imem_addr,
   output logic [INS_W-1:0]       imem_wdata,
   output logic                   cpu_stall,
   output logic                   cpu_pc_reset,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [15:0]            words_loaded
);

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   loader_state_t state_q, state_d;

   logic [15:0]            len_q;
   logic [15:0]            word_idx_q;
   logic [15:0]            words_loaded_q;
   logic                   done_q;
   logic [INS_ADDRESS-1:0] addr_q;
   logic [INS_ADDRESS-1:0] addr_now;
   logic [INS_W-1:0]       wdata_q;
   logic [31:0]            word;
   logic                   word_full;
   logic                   accept;
   logic                   go;
   logic                   last_word;
   logic [15:0]            hdr_len;

   assign accept    = rx_valid && rx_ready;
   assign go        = start && (state_q == IDLE || state_q == ERR);
   assign last_word = (word_idx_q == len_q - 16'd1);
   assign hdr_len   = {rx_data, len_q[7:0]};
   assign addr_now  = BASE_ADDR
                    + INS_ADDRESS'(word_idx_q)
                    * INS_ADDRESS'(WORD_STRIDE);

   word_assembler u_asm (
      .clk       (clk),
      .reset     (reset),
      .clear     (go),
      .byte_in   (rx_data),
      .byte_en   (accept && state_q == DATA),
      .word_out  (word),
      .word_full (word_full)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (start) state_d = HDR0;
         HDR0:   if (accept) state_d = HDR1;
         HDR1: begin
            if (accept) begin
               if (hdr_len == 16'd0)   state_d = FINISH;
               else if (hdr_len > MAX_N) state_d = ERR;
               else                    state_d = DATA;
            end
         end
         DATA:   if (word_full) state_d = WRITE;
         WRITE:  state_d = last_word ? FINISH : DATA;
         FINISH: state_d = IDLE;
         ERR:    if (start) state_d = HDR0;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rx_ready     = 1'b0;
      imem_we      = 1'b0;
      busy         = 1'b0;
      cpu_stall    = 1'b0;
      cpu_pc_reset = 1'b0;
      error        = 1'b0;
      done         = done_q;
      imem_addr    = addr_q;
      imem_wdata   = wdata_q;
      words_loaded = words_loaded_q;
      case (state_q)
         HDR0, HDR1, DATA: begin
            rx_ready  = 1'b1;
            busy      = 1'b1;
            cpu_stall = 1'b1;
         end
         WRITE: begin
            imem_we    = 1'b1;
            busy       = 1'b1;
            cpu_stall  = 1'b1;
            imem_addr  = addr_now;
            imem_wdata = INS_W'(word);
         end
         FINISH: begin
            cpu_pc_reset = 1'b1;
            done         = 1'b1;
         end
         // Keep the core frozen so it never runs a rejected image.
         ERR: begin
            error     = 1'b1;
            cpu_stall = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q          <= '0;
         word_idx_q     <= '0;
         words_loaded_q <= '0;
         done_q         <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
      end else begin
         if (go) begin
            done_q         <= 1'b0;
            words_loaded_q <= '0;
            word_idx_q     <= '0;
         end
         if (state_q == HDR0 && accept) len_q[7:0] <= rx_data;
         if (state_q == HDR1 && accept) len_q <= hdr_len;
         if (state_q == WRITE) begin
            addr_q         <= addr_now;
            wdata_q        <= INS_W'(word);
            words_loaded_q <= words_loaded_q + 16'd1;
            if (!last_word) word_idx_q <= word_idx_q + 16'd1;
         end
         if (state_q == FINISH) done_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised self-checking bench for imem_boot_loader against a
// stream-level model of the expected memory writes.
module tb_imem_boot_loader;

   typedef logic [7:0] u8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_stall;
   logic        cpu_pc_reset;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   imem_boot_loader dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_stall    (cpu_stall),
      .cpu_pc_reset (cpu_pc_reset),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   int          pc_cnt;
   int          we_ready_cnt;
   int          we_nostall_cnt;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         got_addr.push_back(imem_addr);
         got_data.push_back(imem_wdata);
         if (rx_ready !== 1'b0) we_ready_cnt++;
         if (cpu_stall !== 1'b1) we_nostall_cnt++;
      end
      if (cpu_pc_reset === 1'b1) pc_cnt++;
   end

   u8           stream[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_n;
   bit          exp_err;

   task automatic clear_mon();
      got_addr.delete();
      got_data.delete();
      pc_cnt         = 0;
      we_ready_cnt   = 0;
      we_nostall_cnt = 0;
   endtask

   // Expected writes straight from the stream: header length, then
   // little-endian words at consecutive 4-byte addresses.
   task automatic model();
      exp_addr.delete();
      exp_data.delete();
      exp_n   = int'({stream[1], stream[0]});
      exp_err = (exp_n > 15);
      if (!exp_err)
         for (int k = 0; k < exp_n; k++) begin
            exp_addr.push_back(32'(4 * k));
            exp_data.push_back({stream[4*k+5], stream[4*k+4],
                                stream[4*k+3], stream[4*k+2]});
         end
   endtask

   task automatic make_stream(input int n);
      stream.delete();
      stream.push_back(u8'(n));
      stream.push_back(u8'(n >> 8));
      for (int i = 0; i < 4 * n; i++)
         stream.push_back(u8'($urandom_range(255)));
   endtask

   task automatic basic_stream();
      stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00};
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input int nbytes, input int pvalid,
                       input int start_at, output bit ok);
      int idx = 0;
      int cyc = 0;
      bit acc;
      bit pulsed = 0;
      while (idx < nbytes && cyc < 3000) begin
         rx_valid = ($urandom_range(99) < pvalid);
         rx_data  = stream[idx];
         acc      = rx_valid && (rx_ready === 1'b1);
         if (idx == start_at && !pulsed) begin
            start  = 1'b1;
            pulsed = 1;
         end
         @(negedge clk);
         start = 1'b0;
         if (acc) idx++;
         cyc++;
      end
      rx_valid = 1'b0;
      ok = (idx == nbytes);
   endtask

   task automatic wait_idle(input bit start_fin, output bit ok);
      int cyc = 0;
      while (busy === 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      ok = (cyc < 50);
      if (start_fin && cpu_pc_reset === 1'b1) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run_and_check(input string name, input int pvalid,
                                input int start_at, input bit start_fin);
      bit ok;
      clear_mon();
      model();
      do_start();
      n_checks++;
      if ({busy, cpu_stall, rx_ready} !== 3'b111) begin
         n_fail++;
         $display("FAIL %s_busy_on_start: got %b expected 111", name,
                  {busy, cpu_stall, rx_ready});
      end
      send(stream.size(), pvalid, start_at, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s_stream_timeout: got stalled expected all bytes", name);
      end
      if (exp_err) begin
         repeat (3) @(negedge clk);
         n_checks++;
         if ({error, cpu_stall, busy, done, rx_ready} !== 5'b11000) begin
            n_fail++;
            $display("FAIL %s_err_flags: got %b expected 11000", name,
                     {error, cpu_stall, busy, done, rx_ready});
         end
         n_checks++;
         if (got_addr.size() != 0 || words_loaded !== 16'd0) begin
            n_fail++;
            $display("FAIL %s_err_writes: got %0d/%0d expected 0/0", name,
                     got_addr.size(), words_loaded);
         end
         return;
      end
      n_checks++;
      if (exp_n == 0) begin
         if (cpu_pc_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_finish_latency: got %b expected 1", name, cpu_pc_reset);
         end
      end else if ({imem_we, rx_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL %s_write_latency: got %b expected 10", name,
                  {imem_we, rx_ready});
      end
      wait_idle(start_fin, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s_finish_timeout: got busy expected idle", name);
      end
      n_checks++;
      if (got_addr.size() != exp_n) begin
         n_fail++;
         $display("FAIL %s_write_count: got %0d expected %0d", name,
                  got_addr.size(), exp_n);
      end
      for (int k = 0; k < exp_n && k < got_addr.size(); k++) begin
         n_checks++;
         if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
            n_fail++;
            $display("FAIL %s_write%0d: got %h@%h expected %h@%h", name, k,
                     got_data[k], got_addr[k], exp_data[k], exp_addr[k]);
         end
      end
      n_checks++;
      if (pc_cnt != 1) begin
         n_fail++;
         $display("FAIL %s_pc_reset_pulses: got %0d expected 1", name, pc_cnt);
      end
      n_checks++;
      if ({done, error, busy, cpu_stall, rx_ready} !== 5'b10000) begin
         n_fail++;
         $display("FAIL %s_end_flags: got %b expected 10000", name,
                  {done, error, busy, cpu_stall, rx_ready});
      end
      n_checks++;
      if (words_loaded !== 16'(exp_n)) begin
         n_fail++;
         $display("FAIL %s_words_loaded: got %0d expected %0d", name,
                  words_loaded, exp_n);
      end
      n_checks++;
      if (we_ready_cnt != 0 || we_nostall_cnt != 0) begin
         n_fail++;
         $display("FAIL %s_write_cycle_ctrl: got %0d/%0d expected 0/0", name,
                  we_ready_cnt, we_nostall_cnt);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rx_ready, imem_we, cpu_stall, cpu_pc_reset, busy, done, error}
          !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000000",
                  {rx_ready, imem_we, cpu_stall, cpu_pc_reset, busy, done, error});
      end
      n_checks++;
      if (imem_addr !== 32'd0 || imem_wdata !== 32'd0 || words_loaded !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h %h %h expected 0 0 0",
                  imem_addr, imem_wdata, words_loaded);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      basic_stream();
      run_and_check("basic", 100, -1, 0);
      n_checks++;
      if (got_data.size() < 2 || got_data[1] !== 32'h00100093) begin
         n_fail++;
         $display("FAIL basic_literal_word1: got %0d words expected 00100093",
                  got_data.size());
      end
   endtask

   task automatic test_zero_len();
      stream = '{8'h00, 8'h00};
      run_and_check("zero", 100, -1, 0);
   endtask

   task automatic test_error();
      stream = '{8'h10, 8'h00};
      run_and_check("err", 100, -1, 0);
      make_stream(1);
      run_and_check("recover", 70, -1, 0);
   endtask

   task automatic test_random_valid();
      basic_stream();
      run_and_check("basic_rv", 50, -1, 0);
      for (int i = 0; i < 6; i++) begin
         make_stream(i == 0 ? 15 : int'($urandom_range(1, 15)));
         run_and_check("rand", int'($urandom_range(30, 90)), -1, 0);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      make_stream(2);
      clear_mon();
      model();
      do_start();
      send(8, 100, -1, ok);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({rx_ready, imem_we, cpu_stall, cpu_pc_reset, busy, done, error}
          !== 7'b0 || words_loaded !== 16'd0 || imem_addr !== 32'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %b %h %h expected all zero",
                  {rx_ready, imem_we, cpu_stall, cpu_pc_reset, busy, done, error},
                  words_loaded, imem_addr);
      end
      reset = 1'b0;
      repeat (10) @(negedge clk);
      n_checks++;
      if (!ok || got_addr.size() != 1 || pc_cnt != 0) begin
         n_fail++;
         $display("FAIL midreset_writes: got %0d writes %0d pulses expected 1 0",
                  got_addr.size(), pc_cnt);
      end else if (got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0]) begin
         n_fail++;
         $display("FAIL midreset_word0: got %h@%h expected %h@%h",
                  got_data[0], got_addr[0], exp_data[0], exp_addr[0]);
      end
      make_stream(1);
      run_and_check("post_reset", 100, -1, 0);
   endtask

   task automatic test_ignored_start();
      basic_stream();
      run_and_check("ign_start", 100, 4, 1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_error();
      test_random_valid();
      test_reset_mid();
      test_ignored_start();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
